// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared state encoding, requester count and round-robin pick helper
package mux4_rr_arbiter_pkg;
  localparam int NREQ = 4;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/mux4_rr_arbiter_mux4x1.sv
// mux4x1: single-bit 4:1 multiplexer steered by {s1,s0}
module mux4x1 (
  input  logic [3:0] d,
  input  logic       s1,
  input  logic       s0,
  output logic       y
);
  assign y = s1 ? (s0 ? d[3] : d[2]) : (s0 ? d[1] : d[0]);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a 4:1 mux with per-tenure hold limit
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int DW       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*DW-1:0]   din,
  output logic [NREQ-1:0]   gnt,
  output logic              s1,
  output logic              s0,
  output logic              valid,
  output logic [DW-1:0]     dout
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d, sel_q, sel_d, win;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            release_c, busy;
  logic [DW-1:0]   mux_y;
  assign win  = rr_pick(req, ptr_q);
  assign busy = state_q == BUSY;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end
  // A timeout and a dropped request in the same cycle still yield one release.
  always_comb begin
    release_c = !req[sel_q] || hold_q == HOLD_LAST;
    state_d   = busy ? (release_c ? IDLE : BUSY) : (|req ? BUSY : IDLE);
  end
  always_comb begin
    ptr_d  = busy && release_c ? sel_q + 2'd1 : ptr_q;
    sel_d  = !busy && |req ? win : sel_q;
    hold_d = busy && !release_c ? hold_q + HW'(1) : '0;
    gnt_d  = state_d == BUSY ? NREQ'(1) << sel_d : '0;
  end
  for (genvar i = 0; i < DW; i++) begin : g_bit
    mux4x1 u_mux (
      .d ({din[3*DW+i], din[2*DW+i], din[DW+i], din[i]}),
      .s1(sel_q[1]),
      .s0(sel_q[0]),
      .y (mux_y[i])
    );
  end
  always_comb begin
    gnt   = gnt_q;
    s1    = sel_q[1];
    s0    = sel_q[0];
    valid = busy;
    dout  = busy ? mux_y : '0;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin controller that shares one 4:1 multiplexer between four requesters. It arbitrates the request lines and drives the mux select pair (s1,s0) and a one-hot grant. It bounds each tenure with a hold limit and forwards the selected requester's data with a valid flag. It sits in front of the mux4x1 datapath and owns its select lines.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may hold the mux (>=1)
DW, 1, data width of each mux input/output

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
req  input  4  request lines; req[i] belongs to requester i
din  input  4*DW  packed data; din[i*DW +: DW] is requester i's input
gnt  output  4  one-hot grant, registered
s1  output  1  mux select MSB, registered
s0  output  1  mux select LSB, registered
valid  output  1  high while a tenure is active (state BUSY)
dout  output  DW  selected data: din[{s1,s0}] when valid, else 0

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset (sampled at rising edge): state=IDLE, ptr=0, hold_cnt=0, gnt=4'b0000, s1=0, s0=0, valid=0, dout=0. Reset mid-tenure has the same effect at the next edge; the grant is dropped immediately.
- State machine has two states, IDLE and BUSY.
- IDLE, req==0: stay in IDLE; outputs unchanged (s1,s0 keep last index, gnt=0, valid=0).
- IDLE, req!=0: winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - Next edge: gnt=1<<winner, {s1,s0}=winner, valid=1, hold_cnt=0, state=BUSY.
  - Latency from req to gnt is exactly 1 cycle.
- BUSY: dout = din[{s1,s0}] combinationally from the registered select, so there is zero-cycle data latency within a tenure. hold_cnt increments each cycle.
- Release condition: req[{s1,s0}]==0 OR hold_cnt==MAX_HOLD-1. If both are true in the same cycle, only one release occurs.
- On release, next edge: gnt=0, valid=0, ptr=({s1,s0}+1) mod 4 (wraps 3->0), hold_cnt=0, state=IDLE.
- Every tenure is followed by exactly one IDLE bubble cycle. There is no back-to-back grant.
- Changes to other requesters' req lines during BUSY are ignored until IDLE.
- A sole requester that hits the timeout gets one bubble, then is re-granted: the scan from ptr wraps around to it.
- MAX_HOLD=1 gives a one-cycle tenure and a 50% duty cycle under constant request.
- hold_cnt width = $clog2(MAX_HOLD), minimum 1 bit. It never exceeds MAX_HOLD-1.
- Invariants: gnt is always 0 or one-hot; gnt[{s1,s0}]==valid; dout==0 whenever valid==0.

Decomposition:
- Shared package/header: state encodings IDLE=1'b0, BUSY=1'b1; the constant NREQ=4.
- One natural sub-module: the existing mux4x1, instantiated per data bit with {s1,s0} as select. Its output is gated by valid to form dout.
- The arbiter FSM, pointer and hold counter stay in the top module.

Test Plan:
1. Reset, then req=4'b0000 for 5 cycles -> gnt=0000, s1=0, s0=0, valid=0, dout=0 throughout.
2. req=4'b0101 held, MAX_HOLD=8 -> gnt=0001 one cycle after req. After 8 valid cycles, one bubble, then gnt=0100 with {s1,s0}=10. After 8 more cycles and a bubble, gnt=0001 again (wrap).
3. req=4'b1000, din=4'b1000 (DW=1), req[3] dropped after 3 valid cycles -> valid high exactly 3 cycles, dout=1 during them, ptr=0. A following req=4'b1001 is granted to requester 0 first.
4. req[2] drops on the same cycle hold_cnt reaches MAX_HOLD-1 -> a single release: valid falls once, one bubble, no double pointer advance (next winner is scanned from ptr=3).
5. rst asserted during BUSY with gnt=0010 -> next edge gnt=0000, valid=0, {s1,s0}=00. After rst is released with req=4'b0110, the first grant goes to requester 1 (ptr reset to 0).
6. Random req/din for 2000 cycles -> checker confirms one-hot gnt, gnt[{s1,s0}]==valid, dout==din[sel] when valid, tenure <= MAX_HOLD, and no starvation (every asserted requester granted within 4*(MAX_HOLD+1) cycles).
